svm_stage_sched: RTL

SVM_STAGE_SCHED -- requirements
Module: svm_stage_sched

---
 rtl/svm_stage_sched.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/svm_stage_sched.sv
// rtl/svm_stage_sched.sv - stage-1 SVM cascade scheduler: sequences MAC, drain, decision and result capture
//
// Sequences one classification: clear accumulators, feed NUM_OF_PIXELS pixels
// to the dot-product MACs, wait MAC_LAT cycles for the pipeline to drain,
// enable the decision accumulator for NUM_OF_SV rows, then capture the class
// and the cascade-escalation flag from the accumulated decision value.
//
// Ports:
//   clk               - clock, rising edge
//   rst               - asynchronous active-low reset
//   start             - request one classification (ignored while busy)
//   abort             - cancel the operation in progress (ignored in IDLE)
//   decision_funct_in - signed accumulated decision value
//   stall_MEM         - 1 = hold dot-product MACs (0 only while feeding pixels)
//   mac_clr           - clear MAC accumulators
//   pix_idx           - pixel index being fed
//   decision_funct_en - decision accumulator enable
//   sv_idx            - product/kernel row index
//   busy              - operation in progress (includes the done cycle)
//   done              - one-cycle completion pulse
//   y_class           - stage-1 class (1 = decision >= 0)
//   escalate          - forward to the next cascade stage (|decision| < MARGIN)
//   run_count         - completed classifications, wraps at 16 bits
//
// MAC_LAT must be at least 1.

module svm_stage_sched #(
    parameter int                 NUM_OF_PIXELS  = 784,
    parameter int                 NUM_OF_SV      = 87,
    parameter int                 MAC_LAT        = 3,
    parameter int                 DF_SIZE        = 56,
    parameter logic [DF_SIZE-1:0] MARGIN         = 56'd4096,
    // reset value of run_count; 0 in normal use
    parameter logic [15:0]        RUN_COUNT_INIT = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic signed [DF_SIZE-1:0] decision_funct_in,
    output logic                      stall_MEM,
    output logic                      mac_clr,
    output logic [9:0]                pix_idx,
    output logic                      decision_funct_en,
    output logic [6:0]                sv_idx,
    output logic                      busy,
    output logic                      done,
    output logic                      y_class,
    output logic                      escalate,
    output logic [15:0]               run_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MAC,
        S_DRAIN,
        S_DECIDE,
        S_FINISH,
        S_DONE
    } state_t;

    localparam int              DRW        = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [9:0]      PIX_LAST   = 10'(NUM_OF_PIXELS - 1);
    localparam logic [6:0]      SV_LAST    = 7'(NUM_OF_SV - 1);
    localparam logic [DRW-1:0]  DRAIN_LAST = DRW'(MAC_LAT - 1);

    state_t           state_q;
    logic             stall_q;
    logic             mac_clr_q;
    logic [9:0]       pix_idx_q;
    logic             df_en_q;
    logic [6:0]       sv_idx_q;
    logic             busy_q;
    logic             done_q;
    logic             y_class_q;
    logic             escalate_q;
    logic [15:0]      run_count_q;
    logic [DRW-1:0]   drain_q;

    // One extra bit so that the magnitude of the most-negative input
    // (2^(DF_SIZE-1)) is representable and compares as "large", not escalate.
    logic [DF_SIZE:0] df_ext;
    logic [DF_SIZE:0] df_abs;
    logic             escalate_d;

    assign df_ext     = {decision_funct_in[DF_SIZE-1], decision_funct_in};
    assign df_abs     = df_ext[DF_SIZE] ? (~df_ext + 1'b1) : df_ext;
    assign escalate_d = (df_abs < {1'b0, MARGIN});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            stall_q     <= 1'b1;
            mac_clr_q   <= 1'b0;
            pix_idx_q   <= '0;
            df_en_q     <= 1'b0;
            sv_idx_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            y_class_q   <= 1'b0;
            escalate_q  <= 1'b0;
            run_count_q <= RUN_COUNT_INIT;
            drain_q     <= '0;
        end else if (abort && (state_q != S_IDLE)) begin
            // Results and run_count are deliberately left untouched.
            state_q   <= S_IDLE;
            stall_q   <= 1'b1;
            mac_clr_q <= 1'b0;
            pix_idx_q <= '0;
            df_en_q   <= 1'b0;
            sv_idx_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_q   <= '0;
        end else begin
            mac_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_CLEAR;
                        mac_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_q   <= S_MAC;
                    stall_q   <= 1'b0;
                    pix_idx_q <= '0;
                end
                S_MAC: begin
                    if (pix_idx_q == PIX_LAST) begin
                        state_q   <= S_DRAIN;
                        stall_q   <= 1'b1;
                        pix_idx_q <= '0;
                        drain_q   <= '0;
                    end else begin
                        pix_idx_q <= pix_idx_q + 10'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q  <= S_DECIDE;
                        df_en_q  <= 1'b1;
                        sv_idx_q <= '0;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                S_DECIDE: begin
                    if (sv_idx_q == SV_LAST) begin
                        state_q  <= S_FINISH;
                        df_en_q  <= 1'b0;
                        sv_idx_q <= '0;
                    end else begin
                        sv_idx_q <= sv_idx_q + 7'd1;
                    end
                end
                S_FINISH: begin
                    // Decision accumulator has settled; capture results so they
                    // are valid together with the done pulse.
                    state_q     <= S_DONE;
                    y_class_q   <= ~decision_funct_in[DF_SIZE-1];
                    escalate_q  <= escalate_d;
                    done_q      <= 1'b1;
                    run_count_q <= run_count_q + 16'd1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    stall_q   <= 1'b1;
                    pix_idx_q <= '0;
                    df_en_q   <= 1'b0;
                    sv_idx_q  <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign stall_MEM         = stall_q;
    assign mac_clr           = mac_clr_q;
    assign pix_idx           = pix_idx_q;
    assign decision_funct_en = df_en_q;
    assign sv_idx            = sv_idx_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign y_class           = y_class_q;
    assign escalate          = escalate_q;
    assign run_count         = run_count_q;

endmodule
